// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: coefficient/run widths,
// the ZRL marker run, zero-counter width and the encoder state enum.
// BLOCK_SIZE follows `BLOCK_BUFF_SIZE (normally provided by sys_defs.svh);
// a default of 64 is supplied here when no definition is present.
`ifndef BLOCK_BUFF_SIZE
`define BLOCK_BUFF_SIZE 64
`endif

package rle_pkg;

    localparam int BLOCK_SIZE = `BLOCK_BUFF_SIZE;
    localparam int COEFF_W    = 12;
    localparam int RUN_W      = 4;
    localparam int ZRL_RUN    = 15;
    localparam int ZC_W       = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EOB
    } rle_state_e;

endpackage

// File: rtl/rle_next_nz.sv
// Combinational priority encoder: lowest index at or after start whose
// coefficient is nonzero, or BLOCK_SIZE when none remains.
module rle_next_nz #(
    parameter int BLOCK_SIZE = 64,
    parameter int COEFF_W    = 12,
    parameter int IDX_W      = 7
) (
    input  logic signed [COEFF_W-1:0] blk [BLOCK_SIZE],
    input  logic        [IDX_W-1:0]   start,
    output logic        [IDX_W-1:0]   nz_idx
);

    localparam int SEL_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    logic found;

    // Ascending search; the first qualifying index wins.
    always_comb begin
        found  = 1'b0;
        nz_idx = IDX_W'(BLOCK_SIZE);
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            if (!found && (i >= 32'(start)) && (blk[SEL_W'(i)] != '0)) begin
                found  = 1'b1;
                nz_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/run_length_encoder.sv
// Run-length encoder: accepts a whole coefficient block, emits
// (run, value) pairs with ZRL (15,0) beats and a closing (0,0) EOB.
// Optional macro RLE_ZERO_SKIP_EN: skip zero runs in one cycle using
// rle_next_nz; the pair sequence is identical, only timing changes.
module run_length_encoder #(
    parameter int BLOCK_SIZE = rle_pkg::BLOCK_SIZE,
    parameter int COEFF_W    = rle_pkg::COEFF_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [COEFF_W-1:0]     block_in [BLOCK_SIZE],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [rle_pkg::RUN_W-1:0]     run,
    output logic signed [COEFF_W-1:0]     vli_value,
    output logic                          out_eob
);

    import rle_pkg::*;

    localparam int IDX_W = $clog2(BLOCK_SIZE + 1);
    localparam int SEL_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    rle_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ZC_W-1:0]            zc_q, zc_d;
    logic signed [COEFF_W-1:0]  blk_q [BLOCK_SIZE];
    logic signed [COEFF_W-1:0]  cur;
    logic                       advance;
    logic                       capture;
    logic                       load;
    logic [RUN_W-1:0]           ld_run;
    logic signed [COEFF_W-1:0]  ld_val;
    logic                       ld_eob;

    assign in_ready = (state_q == IDLE);
    assign advance  = !out_valid || out_ready;
    assign cur      = blk_q[idx_q[SEL_W-1:0]];

`ifdef RLE_ZERO_SKIP_EN
    logic [IDX_W-1:0] nz_idx;

    rle_next_nz #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .COEFF_W    (COEFF_W),
        .IDX_W      (IDX_W)
    ) u_next_nz (
        .blk    (blk_q),
        .start  (idx_q),
        .nz_idx (nz_idx)
    );
`endif

    // Block capture register, loaded only on an accepted handshake.
    always_ff @(posedge clk) begin
        if (capture) begin
            blk_q <= block_in;
        end
    end

    // State, scan index and pending zero count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            zc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            zc_q    <= zc_d;
        end
    end

    // Next-state and pair generation; all scan progress waits on a free output slot.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        zc_d    = zc_q;
        capture = 1'b0;
        load    = 1'b0;
        ld_run  = '0;
        ld_val  = '0;
        ld_eob  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    zc_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (advance) begin
                    if (idx_q == IDX_W'(BLOCK_SIZE)) begin
                        // trailing zeros are implied by EOB
                        zc_d    = '0;
                        state_d = EOB;
                    end else if (cur == '0) begin
`ifdef RLE_ZERO_SKIP_EN
                        idx_d = nz_idx;
                        zc_d  = zc_q + ZC_W'(nz_idx - idx_q);
`else
                        idx_d = idx_q + IDX_W'(1);
                        zc_d  = zc_q + ZC_W'(1);
`endif
                    end else if (zc_q >= ZC_W'(16)) begin
                        load   = 1'b1;
                        ld_run = RUN_W'(ZRL_RUN);
                        zc_d   = zc_q - ZC_W'(16);
                    end else begin
                        load   = 1'b1;
                        ld_run = zc_q[RUN_W-1:0];
                        ld_val = cur;
                        zc_d   = '0;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            EOB: begin
                if (out_valid && out_eob) begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end else if (advance) begin
                    load   = 1'b1;
                    ld_eob = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered output stage: holds the pair until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            run       <= '0;
            vli_value <= '0;
            out_eob   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            run       <= ld_run;
            vli_value <= ld_val;
            out_eob   <= ld_eob;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_run_length_encoder.sv
// Scoreboard bench for run_length_encoder: directed blocks push their
// hand-computed pair sequences; a negedge monitor compares every presented
// pair and rebuilds the block from the transferred pairs.
module tb_run_length_encoder;

    localparam int BS = 64;
    localparam int CW = 12;

    typedef struct {
        int r;
        int v;
        int e;
    } pair_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [CW-1:0] block_in [BS];
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [3:0]           run;
    logic signed [CW-1:0] vli_value;
    logic                 out_eob;

    pair_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    pops   = 0;
    int    ref_blk [BS];
    int    dec     [BS];
    int    pos     = 0;
    int    blk     [BS];

    always #5 clk = ~clk;

    run_length_encoder #(
        .BLOCK_SIZE (BS),
        .COEFF_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .run       (run),
        .vli_value (vli_value),
        .out_eob   (out_eob)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: compare the presented pair against the queue head every cycle
    // (so a stalled pair is re-checked), pop on transfer, decode on transfer.
    always @(negedge clk) begin
        if (rst) begin
            pos = 0;
            for (int i = 0; i < BS; i++) dec[i] = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", int'(out_valid), 0);
            end else begin
                chk("run", int'(run), exp_q[0].r);
                chk("vli_value", int'(vli_value), exp_q[0].v);
                chk("out_eob", int'(out_eob), exp_q[0].e);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                    if (out_eob) begin
                        int bad;
                        bad = 0;
                        for (int i = 0; i < BS; i++) if (dec[i] != ref_blk[i]) bad++;
                        chk("roundtrip_errors", bad, 0);
                        pos = 0;
                        for (int i = 0; i < BS; i++) dec[i] = 0;
                    end else begin
                        if (pos + int'(run) < BS) dec[pos + int'(run)] = int'(vli_value);
                        pos = pos + int'(run) + 1;
                    end
                end
            end
        end
    end

    task automatic push(input int r, input int v, input int e);
        pair_t p;
        p.r = r; p.v = v; p.e = e;
        exp_q.push_back(p);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < BS; i++) blk[i] = 0;
    endtask

    task automatic send();
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
        for (int i = 0; i < BS; i++) begin
            ref_blk[i]  = blk[i];
            block_in[i] = CW'(blk[i]);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_pair_latency", int'(out_valid), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && in_ready) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops < target && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("pop_wait", int'(pops >= target), 1);
    endtask

    initial begin
        for (int i = 0; i < BS; i++) block_in[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_run", int'(run), 0);
        chk("reset_vli", int'(vli_value), 0);
        chk("reset_eob", int'(out_eob), 0);
        @(posedge clk); #1;

        // all-zero block: EOB only
        clear_blk();
        push(0, 0, 1);
        send(); drain();

        // single DC coefficient
        clear_blk(); blk[0] = 5;
        push(0, 5, 0); push(0, 0, 1);
        send(); drain();

        // 20 leading zeros: one ZRL then run 4
        clear_blk(); blk[20] = -3;
        push(15, 0, 0); push(4, -3, 0); push(0, 0, 1);
        send(); drain();

        // last coefficient nonzero: 62 zeros = 3 ZRL + run 14
        clear_blk(); blk[0] = 1; blk[63] = 7;
        push(0, 1, 0); push(15, 0, 0); push(15, 0, 0); push(15, 0, 0);
        push(14, 7, 0); push(0, 0, 1);
        send(); drain();

        // consumer stall for 5 cycles mid-stream
        clear_blk(); blk[0] = 2; blk[2] = -1; blk[3] = 4; blk[40] = 9;
        push(0, 2, 0); push(1, -1, 0); push(0, 4, 0);
        push(15, 0, 0); push(15, 0, 0); push(4, 9, 0); push(0, 0, 1);
        begin
            int p0;
            p0 = pops;
            send();
            wait_pops(p0 + 1);
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        drain();

        // reset after 3 pairs: block abandoned, no EOB
        clear_blk();
        for (int i = 0; i < 10; i++) blk[i] = i + 1;
        for (int i = 0; i < 10; i++) push(0, i + 1, 0);
        push(0, 0, 1);
        begin
            int p0;
            p0 = pops;
            send();
            wait_pops(p0 + 3);
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_eob", int'(out_eob), 0);
        repeat (5) @(posedge clk);
        #1;

        // next block after reset encodes normally
        clear_blk(); blk[0] = 5;
        push(0, 5, 0); push(0, 0, 1);
        send(); drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
